// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the memory-access stage:
//   - FSM state encoding (IDLE / ACCESS / RESP)
//   - writeback source select encodings (reg_in_sel)
//   - load/store func3 size codes
//   - is_misaligned(): decides whether a load/store must skip the bus
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  // Writeback data source
  localparam logic [1:0] SEL_ALU    = 2'b00;
  localparam logic [1:0] SEL_LOAD   = 2'b01;
  localparam logic [1:0] SEL_IMM    = 2'b10;
  localparam logic [1:0] SEL_PC_IMM = 2'b11;

  // func3 size codes (stores use only B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // An unsupported func3 is folded into the misaligned path so that the
  // access is dropped and flagged rather than issued with a bogus size.
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [2:0] func3,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (func3)
      F3_B:  bad = 1'b0;
      F3_H:  bad = addr_lo[0];
      F3_W:  bad = (addr_lo != 2'b00);
      F3_BU: bad = is_store;
      F3_HU: bad = is_store | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load-data formatter: picks the byte/half lane addressed by
// addr_lo out of a 32-bit memory word and sign- or zero-extends it.
// Ports:
//   rdata   in  32  raw word read from data memory
//   addr_lo in   2  byte offset of the load address
//   func3   in   3  load size / signedness code
//   result  out 32  extended load value (0 for unsupported func3)
// -----------------------------------------------------------------------------
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = byte_lane[addr_lo];
  // Half loads are only issued on even offsets, so addr_lo[1] picks the half.
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = 32'h0;
    case (func3)
      F3_B:  result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:  result = {{16{half_sel[15]}}, half_sel};
      F3_W:  result = rdata;
      F3_BU: result = {24'h0, byte_sel};
      F3_HU: result = {16'h0, half_sel};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory stage: accepts one op at a time from execute, performs at most one
// data-memory transaction for it, and presents a single-cycle writeback.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake (ready only in IDLE)
//   in_alu_out .. in_reg_wr    op payload latched on the accepting edge
//   dm_req/we/addr/be/wdata    data-memory request, held until dm_ack
//   dm_ack, dm_rdata           data-memory completion and read data
//   wb_valid, wb_rd, wb_reg_wr, wb_data   one-cycle writeback
//   misalign_err               pulses with wb_valid for dropped accesses
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_store_data,
  input  logic [31:0] in_pc_imm,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_reg_in_sel,
  input  logic [3:0]  in_dwe,
  input  logic [2:0]  in_func3,
  input  logic        in_mem_reg,
  input  logic        in_reg_wr,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_wr,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  state_t state_reg, state_next;

  // EX/MEM payload register
  logic [31:0] alu_out_reg;
  logic [31:0] store_data_reg;
  logic [31:0] pc_imm_reg;
  logic [31:0] imm_reg;
  logic [4:0]  rd_reg;
  logic [1:0]  reg_in_sel_reg;
  logic [2:0]  func3_reg;
  logic        reg_wr_reg;
  logic        is_store_reg;
  logic        is_load_reg;
  logic        misalign_reg;
  logic [31:0] rdata_reg;

  logic        accept;
  logic        in_is_store;
  logic        in_is_load;
  logic        in_misalign;
  logic        in_access;
  logic [1:0]  addr_lo;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_aligned;
  logic [31:0] load_data;

  // ---------------------------------------------------------------------------
  // Upstream classification (store wins over load)
  // ---------------------------------------------------------------------------
  assign in_ready    = (state_reg == IDLE);
  assign accept      = in_valid && in_ready;
  assign in_is_store = (in_dwe != 4'b0000);
  assign in_is_load  = !in_is_store && in_mem_reg;
  assign in_misalign = (in_is_store || in_is_load) &&
                       is_misaligned(in_is_store, in_func3, in_alu_out[1:0]);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if ((in_is_store || in_is_load) && !in_misalign) begin
            state_next = ACCESS;
          end else begin
            state_next = RESP;
          end
        end
      end
      ACCESS: begin
        if (dm_ack) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Payload latch and read-data capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_reg    <= 32'h0;
      store_data_reg <= 32'h0;
      pc_imm_reg     <= 32'h0;
      imm_reg        <= 32'h0;
      rd_reg         <= 5'h0;
      reg_in_sel_reg <= 2'b00;
      func3_reg      <= 3'b000;
      reg_wr_reg     <= 1'b0;
      is_store_reg   <= 1'b0;
      is_load_reg    <= 1'b0;
      misalign_reg   <= 1'b0;
      rdata_reg      <= 32'h0;
    end else begin
      if (accept) begin
        alu_out_reg    <= in_alu_out;
        store_data_reg <= in_store_data;
        pc_imm_reg     <= in_pc_imm;
        imm_reg        <= in_imm;
        rd_reg         <= in_rd;
        reg_in_sel_reg <= in_reg_in_sel;
        func3_reg      <= in_func3;
        reg_wr_reg     <= in_reg_wr;
        is_store_reg   <= in_is_store;
        is_load_reg    <= in_is_load;
        misalign_reg   <= in_misalign;
      end
      // Only an ack seen in ACCESS completes a transfer; stray acks are dropped.
      if ((state_reg == ACCESS) && dm_ack) begin
        rdata_reg <= dm_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data-memory request (decoded from registered state, so it is stable for the
  // whole ACCESS period and drops as soon as reset asserts)
  // ---------------------------------------------------------------------------
  assign in_access = (state_reg == ACCESS);
  assign addr_lo   = alu_out_reg[1:0];

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = store_data_reg;
    if (is_store_reg) begin
      case (func3_reg)
        F3_B: begin
          be_calc    = 4'b0001 << addr_lo;
          wdata_calc = {4{store_data_reg[7:0]}};
        end
        F3_H: begin
          be_calc    = 4'b0011 << addr_lo;
          wdata_calc = {2{store_data_reg[15:0]}};
        end
        default: begin
          be_calc    = 4'b1111;
          wdata_calc = store_data_reg;
        end
      endcase
    end
  end

  assign dm_req   = in_access;
  assign dm_we    = in_access && is_store_reg;
  assign dm_addr  = {alu_out_reg[31:2], 2'b00};
  assign dm_be    = in_access ? be_calc : 4'b0000;
  assign dm_wdata = wdata_calc;

  // ---------------------------------------------------------------------------
  // Writeback
  // ---------------------------------------------------------------------------
  load_align u_load_align (
    .rdata   (rdata_reg),
    .addr_lo (addr_lo),
    .func3   (func3_reg),
    .result  (load_aligned)
  );

  // A store that selects load data writes back zero, not the bus read value.
  assign load_data = is_load_reg ? load_aligned : 32'h0;

  always_comb begin
    wb_data = alu_out_reg;
    case (reg_in_sel_reg)
      SEL_ALU:    wb_data = alu_out_reg;
      SEL_LOAD:   wb_data = load_data;
      SEL_IMM:    wb_data = imm_reg;
      SEL_PC_IMM: wb_data = pc_imm_reg;
      default:    wb_data = alu_out_reg;
    endcase
  end

  assign wb_valid     = (state_reg == RESP);
  assign wb_rd        = rd_reg;
  assign wb_reg_wr    = wb_valid && reg_wr_reg && !misalign_reg;
  assign misalign_err = wb_valid && misalign_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit. Every task starts and ends
// on a falling clock edge; inputs change there and outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_out;
  logic [31:0] in_store_data;
  logic [31:0] in_pc_imm;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic [1:0]  in_reg_in_sel;
  logic [3:0]  in_dwe;
  logic [2:0]  in_func3;
  logic        in_mem_reg;
  logic        in_reg_wr;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_wr;
  logic [31:0] wb_data;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  mem_access_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_out    (in_alu_out),
    .in_store_data (in_store_data),
    .in_pc_imm     (in_pc_imm),
    .in_imm        (in_imm),
    .in_rd         (in_rd),
    .in_reg_in_sel (in_reg_in_sel),
    .in_dwe        (in_dwe),
    .in_func3      (in_func3),
    .in_mem_reg    (in_mem_reg),
    .in_reg_wr     (in_reg_wr),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_be         (dm_be),
    .dm_wdata      (dm_wdata),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_reg_wr     (wb_reg_wr),
    .wb_data       (wb_data),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op for exactly one rising edge; returns on the falling edge
  // one cycle after the accepting edge.
  task automatic drive_op(input logic [31:0] alu, input logic [31:0] sdata,
                          input logic [31:0] pcimm, input logic [31:0] imm,
                          input logic [4:0] rd, input logic [1:0] sel,
                          input logic [3:0] dwe, input logic [2:0] f3,
                          input logic mr, input logic rw);
    in_alu_out    = alu;
    in_store_data = sdata;
    in_pc_imm     = pcimm;
    in_imm        = imm;
    in_rd         = rd;
    in_reg_in_sel = sel;
    in_dwe        = dwe;
    in_func3      = f3;
    in_mem_reg    = mr;
    in_reg_wr     = rw;
    in_valid      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_alu_out = 32'h0; in_store_data = 32'h0;
    in_pc_imm = 32'h0; in_imm = 32'h0; in_rd = 5'h0; in_reg_in_sel = 2'b00;
    in_dwe = 4'h0; in_func3 = 3'b000; in_mem_reg = 1'b0; in_reg_wr = 1'b0;
    dm_ack = 1'b0; dm_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({dm_req, dm_we, dm_be, wb_valid, wb_reg_wr, misalign_err} !== 9'h0)
      begin errors++; $display("FAIL reset_outputs: got %b expected 000000000",
        {dm_req, dm_we, dm_be, wb_valid, wb_reg_wr, misalign_err}); end
    checks++;
    if (wb_data !== 32'h0 || wb_rd !== 5'h0)
      begin errors++; $display("FAIL reset_payload: got data=%h rd=%0d expected 0/0", wb_data, wb_rd); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    $display("[%0t] reset released, in_ready=%b", $time, in_ready);
  endtask

  task automatic test_pass_through(input logic [1:0] sel, input logic [31:0] exp_data);
    checks++;
    if (in_ready !== 1'b1)
      begin errors++; $display("FAIL pt_ready_before: got %b expected 1", in_ready); end
    drive_op(32'h0000_1234, 32'h0, 32'hAAAA_0000, 32'h0000_0055, 5'd5, sel, 4'h0, 3'b000, 1'b0, 1'b1);
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== exp_data || wb_rd !== 5'd5 || wb_reg_wr !== 1'b1)
      begin errors++; $display("FAIL pt_wb: got v=%b data=%h rd=%0d wr=%b expected 1/%h/5/1",
        wb_valid, wb_data, wb_rd, wb_reg_wr, exp_data); end
    checks++;
    if (dm_req !== 1'b0 || misalign_err !== 1'b0)
      begin errors++; $display("FAIL pt_no_bus: got req=%b err=%b expected 0/0", dm_req, misalign_err); end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL pt_end: got v=%b ready=%b expected 0/1", wb_valid, in_ready); end
    $display("[%0t] pass-through sel=%b wb_data=%h", $time, sel, exp_data);
  endtask

  // Store with 'waits' idle cycles before dm_ack; request must last waits+1 cycles.
  task automatic test_store(input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [2:0] f3, input int waits,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
    int req_cycles;
    req_cycles = 0;
    drive_op(addr, sdata, 32'h0, 32'h0, 5'd9, 2'b01, 4'hF, f3, 1'b0, 1'b1);
    for (int i = 0; i <= waits; i++) begin
      if (dm_req === 1'b1) req_cycles++;
      checks++;
      if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_addr !== exp_addr ||
          dm_be !== exp_be || dm_wdata !== exp_wdata)
        begin errors++; $display("FAIL st_bus[%0d]: got req=%b we=%b addr=%h be=%b wdata=%h expected 1/1/%h/%b/%h",
          i, dm_req, dm_we, dm_addr, dm_be, dm_wdata, exp_addr, exp_be, exp_wdata); end
      if (i == waits) begin
        dm_ack = 1'b1;
        dm_rdata = 32'hFFFF_FFFF;
      end
      @(negedge clk);
    end
    dm_ack = 1'b0;
    checks++;
    if (req_cycles != waits + 1 || dm_req !== 1'b0)
      begin errors++; $display("FAIL st_req_len: got %0d cycles, req now %b expected %0d/0",
        req_cycles, dm_req, waits + 1); end
    // reg_in_sel=01 on a store writes back zero
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0 || wb_reg_wr !== 1'b1 || misalign_err !== 1'b0)
      begin errors++; $display("FAIL st_wb: got v=%b data=%h wr=%b err=%b expected 1/00000000/1/0",
        wb_valid, wb_data, wb_reg_wr, misalign_err); end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0)
      begin errors++; $display("FAIL st_wb_len: got %b expected 0", wb_valid); end
    $display("[%0t] store addr=%h be=%b wdata=%h", $time, addr, exp_be, exp_wdata);
  endtask

  task automatic test_load(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] exp_data);
    drive_op(addr, 32'h0, 32'h0, 32'h0, 5'd7, 2'b01, 4'h0, f3, 1'b1, 1'b1);
    checks++;
    if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_be !== 4'b1111 ||
        dm_addr !== {addr[31:2], 2'b00})
      begin errors++; $display("FAIL ld_bus: got req=%b we=%b be=%b addr=%h expected 1/0/1111/%h",
        dm_req, dm_we, dm_be, dm_addr, {addr[31:2], 2'b00}); end
    dm_ack = 1'b1;
    dm_rdata = rdata;
    @(negedge clk);
    dm_ack = 1'b0;
    dm_rdata = 32'h0;
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== exp_data || wb_rd !== 5'd7 || wb_reg_wr !== 1'b1 || dm_req !== 1'b0)
      begin errors++; $display("FAIL ld_wb: got v=%b data=%h rd=%0d wr=%b req=%b expected 1/%h/7/1/0",
        wb_valid, wb_data, wb_rd, wb_reg_wr, dm_req, exp_data); end
    @(negedge clk);
    $display("[%0t] load addr=%h f3=%b rdata=%h wb_data=%h", $time, addr, f3, rdata, exp_data);
  endtask

  task automatic test_misalign(input logic [31:0] addr, input logic [2:0] f3,
                               input logic is_store);
    drive_op(addr, 32'h1111_2222, 32'h0, 32'h0, 5'd4, 2'b01,
             is_store ? 4'hF : 4'h0, f3, ~is_store, 1'b1);
    checks++;
    if (dm_req !== 1'b0 || wb_valid !== 1'b1 || misalign_err !== 1'b1 || wb_reg_wr !== 1'b0)
      begin errors++; $display("FAIL mis_wb: got req=%b v=%b err=%b wr=%b expected 0/1/1/0",
        dm_req, wb_valid, misalign_err, wb_reg_wr); end
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b0 || wb_valid !== 1'b0 || dm_req !== 1'b0)
      begin errors++; $display("FAIL mis_end: got err=%b v=%b req=%b expected 0/0/0",
        misalign_err, wb_valid, dm_req); end
    $display("[%0t] misaligned op addr=%h f3=%b store=%b", $time, addr, f3, is_store);
  endtask

  task automatic test_stray_ack();
    dm_ack = 1'b1;
    dm_rdata = 32'h1234_5678;
    @(negedge clk);
    dm_ack = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1 || dm_req !== 1'b0)
      begin errors++; $display("FAIL stray_ack: got v=%b ready=%b req=%b expected 0/1/0",
        wb_valid, in_ready, dm_req); end
    $display("[%0t] stray ack in IDLE ignored", $time);
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      in_alu_out = 32'h100 + 32'(k);
      in_store_data = 32'h0; in_pc_imm = 32'h0; in_imm = 32'h0;
      in_rd = 5'(10 + k); in_reg_in_sel = 2'b00; in_dwe = 4'h0;
      in_func3 = 3'b000; in_mem_reg = 1'b0; in_reg_wr = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      if (wb_valid === 1'b1) pulses++;
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h100 + 32'(k) || wb_rd !== 5'(10 + k) || in_ready !== 1'b0)
        begin errors++; $display("FAIL b2b_wb[%0d]: got v=%b data=%h rd=%0d ready=%b expected 1/%h/%0d/0",
          k, wb_valid, wb_data, wb_rd, in_ready, 32'h100 + 32'(k), 10 + k); end
      @(negedge clk);
      if (wb_valid === 1'b1) pulses++;
      $display("[%0t] back-to-back op %0d wb_data=%h", $time, k, 32'h100 + 32'(k));
    end
    in_valid = 1'b0;
    @(negedge clk);
    if (wb_valid === 1'b1) pulses++;
    checks++;
    if (pulses != 3)
      begin errors++; $display("FAIL b2b_count: got %0d writebacks expected 3", pulses); end
  endtask

  task automatic test_reset_mid_access();
    drive_op(32'h0000_0200, 32'h0, 32'h0, 32'h0, 5'd3, 2'b01, 4'h0, 3'b010, 1'b1, 1'b1);
    checks++;
    if (dm_req !== 1'b1)
      begin errors++; $display("FAIL rst_mid_req: got %b expected 1", dm_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dm_req !== 1'b0 || dm_be !== 4'b0000 || wb_valid !== 1'b0 || wb_rd !== 5'h0)
      begin errors++; $display("FAIL rst_mid_async: got req=%b be=%b v=%b rd=%0d expected 0/0000/0/0",
        dm_req, dm_be, wb_valid, wb_rd); end
    @(negedge clk);
    rst_n = 1'b1;
    dm_ack = 1'b1;
    dm_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dm_ack = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || dm_req !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL rst_late_ack: got v=%b req=%b ready=%b expected 0/0/1",
        wb_valid, dm_req, in_ready); end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL rst_after: got v=%b ready=%b expected 0/1", wb_valid, in_ready); end
    $display("[%0t] reset during ACCESS aborted transfer", $time);
  endtask

  initial begin
    test_reset();
    test_pass_through(2'b00, 32'h0000_1234);
    test_pass_through(2'b10, 32'h0000_0055);
    test_pass_through(2'b11, 32'hAAAA_0000);
    test_store(32'h0000_0103, 32'h0000_00AB, 3'b000, 3, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB);
    test_store(32'h0000_0102, 32'h1234_CDEF, 3'b001, 0, 32'h0000_0100, 4'b1100, 32'hCDEF_CDEF);
    test_store(32'h0000_0104, 32'h89AB_CDEF, 3'b010, 1, 32'h0000_0104, 4'b1111, 32'h89AB_CDEF);
    test_load(32'h0000_0101, 3'b000, 32'h0000_8000, 32'hFFFF_FF80);
    test_load(32'h0000_0101, 3'b100, 32'h0000_8000, 32'h0000_0080);
    test_load(32'h0000_0102, 3'b001, 32'h8001_0000, 32'hFFFF_8001);
    test_load(32'h0000_0102, 3'b101, 32'h8001_0000, 32'h0000_8001);
    test_load(32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    test_misalign(32'h0000_0102, 3'b010, 1'b0);
    test_misalign(32'h0000_0101, 3'b001, 1'b1);
    test_misalign(32'h0000_0100, 3'b011, 1'b0);
    test_stray_ack();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk input 1 system clock; rst_n input 1 asynchronous active-low reset.
REQ-002 SHALL have upstream ports: in_valid input 1, op present; in_ready output 1, op accepted when both high at clk rise.
REQ-003 SHALL have upstream payload inputs: in_alu_out 32 (address/result), in_store_data 32, in_pc_imm 32, in_imm 32, in_rd 5, in_reg_in_sel 2, in_dwe 4 (nonzero = store), in_func3 3, in_mem_reg 1 (load), in_reg_wr 1.
REQ-004 SHALL have data-memory ports: dm_req output 1, dm_we output 1, dm_addr output 32 (word-aligned), dm_be output 4, dm_wdata output 32, dm_ack input 1, dm_rdata input 32.
REQ-005 SHALL have writeback ports: wb_valid output 1, wb_rd output 5, wb_reg_wr output 1, wb_data output 32, misalign_err output 1.

Function
REQ-006 FSM states: IDLE, ACCESS, RESP. in_ready = (state==IDLE).
REQ-007 Accepted op latched into internal EX/MEM register on the accepting edge.
REQ-008 Op class: store if in_dwe!=0 (takes priority over load); else load if in_mem_reg; else pass-through.
REQ-009 Pass-through: IDLE->RESP; wb_valid high exactly 1 cycle after accept, then RESP->IDLE.
REQ-010 Load/store (aligned): IDLE->ACCESS; dm_req high from cycle after accept, held with stable dm_addr/dm_we/dm_be/dm_wdata until dm_ack sampled high.
REQ-011 On dm_ack: dm_req low the next cycle, dm_rdata captured, ACCESS->RESP; wb_valid high the cycle after ack, for 1 cycle.
REQ-012 dm_ack while not in ACCESS SHALL be ignored.
REQ-013 dm_addr = {addr[31:2],2'b00}; dm_we=1 for stores only.
REQ-014 Store func3 000/001/010 = byte/half/word; dm_be = 0001<<a, 0011<<a, 1111 (a = addr[1:0]); dm_wdata = byte replicated x4, half replicated x2, or word.
REQ-015 Load func3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; dm_be=1111; lane selected by addr[1:0]; sign- or zero-extended to 32.
REQ-016 Misaligned (half with a[0]=1, word with a!=0): no bus request; IDLE->RESP; wb_valid 1 cycle with wb_reg_wr=0; misalign_err pulses same cycle.
REQ-017 Unsupported func3 on load/store SHALL be treated as misaligned.
REQ-018 wb_data by latched reg_in_sel: 00 alu_out, 01 load data, 10 imm, 11 pc_imm.
REQ-019 wb_rd, wb_reg_wr SHALL equal latched values (except REQ-016); stores with reg_in_sel 01 still write load value 0.
REQ-020 Back-to-back pass-through ops: throughput one op per 2 cycles; no op dropped or duplicated.

Reset
REQ-021 rst_n low SHALL asynchronously force state=IDLE and dm_req, dm_we, dm_be, wb_valid, wb_reg_wr, misalign_err, and all latched payload to 0.
REQ-022 Reset during ACCESS SHALL abort the transfer; dm_ack arriving after reset release SHALL be ignored.
REQ-023 in_ready SHALL be 1 from the first cycle after reset release.

Structure
REQ-024 Shared package SHALL hold reg_in_sel encodings, func3 load/store codes, state enum.
REQ-025 One combinational sub-module load_align (dm_rdata, addr[1:0], func3 -> 32-bit result).

Verification
REQ-026 Pass-through: reg_in_sel=00, alu_out=0x1234, rd=5, reg_wr=1 -> wb_valid 1 cycle after accept, wb_data=0x1234, no dm_req.
REQ-027 SB at addr 0x103, data 0xAB, ack after 3 wait cycles -> dm_addr=0x100, be=1000, wdata=0xABABABAB, req held 4 cycles.
REQ-028 LB at 0x101, dm_rdata=0x0000_8000 -> wb_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-029 LW at 0x102 -> no dm_req, misalign_err pulse, wb_reg_wr=0.
REQ-030 rst_n asserted mid-ACCESS, then late dm_ack -> dm_req low immediately, no wb_valid, in_ready=1 after release.
